// File: rtl/op_arbiter.sv
// Round-robin arbiter/sequencer: grants one of two requesters, drives the operands onto a
// fixed-latency compute unit, captures the result after LATENCY and returns it to the owner.
module op_arbiter #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 6,
  parameter int C_WIDTH = 5,
  parameter int LATENCY = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               req0_valid_in,
  input  logic [A_WIDTH-1:0] req0_a_in,
  input  logic [B_WIDTH-1:0] req0_b_in,
  output logic               req0_ready_out,
  output logic               req0_result_valid_out,
  output logic [C_WIDTH-1:0] req0_result_out,
  input  logic               req1_valid_in,
  input  logic [A_WIDTH-1:0] req1_a_in,
  input  logic [B_WIDTH-1:0] req1_b_in,
  output logic               req1_ready_out,
  output logic               req1_result_valid_out,
  output logic [C_WIDTH-1:0] req1_result_out,
  output logic [A_WIDTH-1:0] dp_a_out,
  output logic [B_WIDTH-1:0] dp_b_out,
  input  logic [C_WIDTH-1:0] dp_c_in,
  output logic               busy_out
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 prio_q, prio_d;
  logic                 owner_q, owner_d;
  logic [A_WIDTH-1:0]   dp_a_q, dp_a_d;
  logic [B_WIDTH-1:0]   dp_b_q, dp_b_d;
  logic [C_WIDTH-1:0]   res0_q, res0_d;
  logic [C_WIDTH-1:0]   res1_q, res1_d;
  logic                 rv0_q, rv0_d;
  logic                 rv1_q, rv1_d;
  logic                 rdy0_s, rdy1_s;
  logic                 xfer0_s, xfer1_s;

  // Grant decode: only in IDLE and never while reset is asserted; ties go to prio_q.
  always_comb begin
    rdy0_s = 1'b0;
    rdy1_s = 1'b0;
    if (!rst_in && (state_q == ST_IDLE)) begin
      if (req0_valid_in && req1_valid_in) begin
        rdy0_s = (prio_q == 1'b0);
        rdy1_s = (prio_q == 1'b1);
      end else begin
        rdy0_s = req0_valid_in;
        rdy1_s = req1_valid_in;
      end
    end else begin
      rdy0_s = 1'b0;
      rdy1_s = 1'b0;
    end
  end

  assign xfer0_s = req0_valid_in & rdy0_s;
  assign xfer1_s = req1_valid_in & rdy1_s;

  // Next-state logic for the sequencer, operand registers and result ports.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    dp_a_d  = dp_a_q;
    dp_b_d  = dp_b_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer0_s || xfer1_s) begin
          owner_d = xfer1_s;
          dp_a_d  = xfer1_s ? req1_a_in : req0_a_in;
          dp_b_d  = xfer1_s ? req1_b_in : req0_b_in;
          cnt_d   = LAT_C;
          prio_d  = ~xfer1_s;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The unit's result is valid on this edge; hand it to the owner only.
          state_d = ST_IDLE;
          if (owner_q) begin
            res1_d = dp_c_in;
            rv1_d  = 1'b1;
          end else begin
            res0_d = dp_c_in;
            rv0_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset also aborts any in-flight op.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      dp_a_q  <= dp_a_d;
      dp_b_q  <= dp_b_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign req0_ready_out        = rdy0_s;
  assign req1_ready_out        = rdy1_s;
  assign req0_result_valid_out = rv0_q;
  assign req1_result_valid_out = rv1_q;
  assign req0_result_out       = res0_q;
  assign req1_result_out       = res1_q;
  assign dp_a_out              = dp_a_q;
  assign dp_b_out              = dp_b_q;
  assign busy_out              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_op_arbiter.sv
// Directed bench for op_arbiter with a LAT-stage (a+b)&0x1F compute-unit model.
module tb_op_arbiter;
  parameter int LAT = 1;
  localparam int PIDX = (LAT == 0) ? 0 : LAT - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [5:0] req0_a = 6'd0, req0_b = 6'd0, req1_a = 6'd0, req1_b = 6'd0;
  logic       req0_ready, req1_ready, rv0, rv1, busy;
  logic [4:0] res0, res1, dp_c;
  logic [5:0] dp_a, dp_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_res0 = 5'd0;
  logic [4:0] exp_res1 = 5'd0;

  op_arbiter #(.A_WIDTH(6), .B_WIDTH(6), .C_WIDTH(5), .LATENCY(LAT)) dut (
    .clk_in(clk), .rst_in(rst),
    .req0_valid_in(req0_valid), .req0_a_in(req0_a), .req0_b_in(req0_b),
    .req0_ready_out(req0_ready), .req0_result_valid_out(rv0), .req0_result_out(res0),
    .req1_valid_in(req1_valid), .req1_a_in(req1_a), .req1_b_in(req1_b),
    .req1_ready_out(req1_ready), .req1_result_valid_out(rv1), .req1_result_out(res1),
    .dp_a_out(dp_a), .dp_b_out(dp_b), .dp_c_in(dp_c), .busy_out(busy)
  );

  always #5 clk = ~clk;

  // Compute-unit model: sum truncated to 5 bits, delayed LAT edges.
  logic [6:0] full_sum;
  logic [4:0] pipe [0:15];
  assign full_sum = {1'b0, dp_a} + {1'b0, dp_b};
  always @(posedge clk) begin
    pipe[0] <= full_sum[4:0];
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_c = (LAT == 0) ? full_sum[4:0] : pipe[PIDX];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation starting in an IDLE cycle; own is the hand-derived winner.
  task automatic do_op(input logic v0, input logic v1, input logic [5:0] a0, input logic [5:0] b0,
                       input logic [5:0] a1, input logic [5:0] b1, input logic own);
    logic [5:0] ea, eb;
    logic [6:0] s;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    chk("ready0_grant", 32'(req0_ready), 32'(own == 1'b0));
    chk("ready1_grant", 32'(req1_ready), 32'(own == 1'b1));
    ea = own ? a1 : a0;
    eb = own ? b1 : b0;
    s  = {1'b0, ea} + {1'b0, eb};
    step();
    for (int k = 0; k <= LAT; k++) begin
      chk("dp_a_hold", 32'(dp_a), 32'(ea));
      chk("dp_b_hold", 32'(dp_b), 32'(eb));
      chk("busy_wait", 32'(busy), 32'd1);
      chk("ready0_wait", 32'(req0_ready), 32'd0);
      chk("ready1_wait", 32'(req1_ready), 32'd0);
      chk("rv0_wait", 32'(rv0), 32'd0);
      chk("rv1_wait", 32'(rv1), 32'd0);
      step();
    end
    if (own) exp_res1 = s[4:0];
    else     exp_res0 = s[4:0];
    chk("rv0_pulse", 32'(rv0), 32'(own == 1'b0));
    chk("rv1_pulse", 32'(rv1), 32'(own == 1'b1));
    chk("res0", 32'(res0), 32'(exp_res0));
    chk("res1", 32'(res1), 32'(exp_res1));
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset held two edges with both requesters valid.
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 6'd11; req0_b = 6'd12; req1_a = 6'd21; req1_b = 6'd22;
    step();
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    step();
    chk("rst_dp_a", 32'(dp_a), 32'd0);
    chk("rst_dp_b", 32'(dp_b), 32'd0);
    chk("rst_res0", 32'(res0), 32'd0);
    chk("rst_res1", 32'(res1), 32'd0);
    chk("rst_rv0", 32'(rv0), 32'd0);
    chk("rst_rv1", 32'(rv1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready0", 32'(req0_ready), 32'd1);
    chk("idle_ready1", 32'(req1_ready), 32'd0);
    // Valid dropped before the edge: no transfer.
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("drop_busy", 32'(busy), 32'd0);

    // Single op from requester 0: 5+9 = 14.
    do_op(1'b1, 1'b0, 6'd5, 6'd9, 6'd0, 6'd0, 1'b0);
    chk("single_res0_14", 32'(res0), 32'd14);
    req0_valid = 1'b0;
    step();
    chk("single_rv0_drop", 32'(rv0), 32'd0);
    chk("single_res0_hold", 32'(res0), 32'd14);

    // Priority memory: prio is 1 after the req0 grant; req1 alone, then ties alternate.
    do_op(1'b0, 1'b1, 6'd0, 6'd0, 6'd30, 6'd7, 1'b1);
    do_op(1'b1, 1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 1'b0);
    do_op(1'b1, 1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 1'b1);

    // Contention, operands changing per grant: order 0,1,0,1 back to back.
    do_op(1'b1, 1'b1, 6'd40, 6'd17, 6'd50, 6'd13, 1'b0);
    do_op(1'b1, 1'b1, 6'd8, 6'd8, 6'd50, 6'd13, 1'b1);
    do_op(1'b1, 1'b1, 6'd8, 6'd8, 6'd63, 6'd1, 1'b0);
    do_op(1'b1, 1'b1, 6'd2, 6'd33, 6'd63, 6'd1, 1'b1);

    // Reset one cycle after accepting req1 63+63: op aborted, prio back to 0.
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 6'd63; req1_b = 6'd63;
    #1;
    chk("abort_ready1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_res0 = 5'd0;
    exp_res1 = 5'd0;
    for (int k = 0; k < LAT + 3; k++) begin
      chk("abort_rv1", 32'(rv1), 32'd0);
      chk("abort_res1", 32'(res1), 32'd0);
      step();
    end
    chk("abort_busy", 32'(busy), 32'd0);
    do_op(1'b1, 1'b1, 6'd9, 6'd10, 6'd1, 6'd1, 1'b0);

    // Eight back-to-back single-requester ops.
    for (int i = 0; i < 8; i++) begin
      logic [5:0] ta, tb;
      ta = 6'(i * 13 + 3);
      tb = 6'(i * 29 + 7);
      do_op(1'b1, 1'b0, ta, tb, 6'd0, 6'd0, 1'b0);
    end
    req0_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
